// File: rtl/gauss_window_gen_pkg.sv
// rtl/gauss_window_gen_pkg.sv - corner_type codes and FSM states shared with the Gaussian computing block
package gauss_window_gen_pkg;

  localparam logic [3:0] CT_IDLE = 4'd0;
  localparam logic [3:0] CT_TL   = 4'd1;
  localparam logic [3:0] CT_TR   = 4'd2;
  localparam logic [3:0] CT_L    = 4'd3;
  localparam logic [3:0] CT_R    = 4'd4;
  localparam logic [3:0] CT_BL   = 4'd5;
  localparam logic [3:0] CT_BR   = 4'd6;
  localparam logic [3:0] CT_B    = 4'd7;
  localparam logic [3:0] CT_FULL = 4'd8;

  typedef enum logic [1:0] {FILL, STREAM, FLUSH} state_t;

  // A top-row centre that is not a corner uses the full kernel.
  function automatic logic [3:0] corner_code(input logic top, input logic bot,
                                             input logic left, input logic right);
    if (top && left)  return CT_TL;
    if (top && right) return CT_TR;
    if (bot && left)  return CT_BL;
    if (bot && right) return CT_BR;
    if (bot)          return CT_B;
    if (left)         return CT_L;
    if (right)        return CT_R;
    return CT_FULL;
  endfunction

endpackage

// File: rtl/gauss_window_gen_line_fifo.sv
// rtl/gauss_window_gen_line_fifo.sv - gauss_line_fifo: one-line delay line, dout is the pixel shifted in DEPTH shifts ago
module gauss_line_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         ptr;

  // Read-before-write circular buffer: the slot about to be overwritten holds the oldest pixel.
  assign dout = mem[ptr];

  always_ff @(posedge clk) begin
    if (shift_en) mem[ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/gauss_window_gen.sv
// rtl/gauss_window_gen.sv - streaming 3x3 window generator with corner codes
// Optional GAUSS_WIN_REPLICATE_EN: edge replication instead of zero padding.
module gauss_window_gen
  import gauss_window_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] line0_data0,
  output logic [DATA_WIDTH-1:0] line0_data1,
  output logic [DATA_WIDTH-1:0] line0_data2,
  output logic [DATA_WIDTH-1:0] line1_data0,
  output logic [DATA_WIDTH-1:0] line1_data1,
  output logic [DATA_WIDTH-1:0] line1_data2,
  output logic [DATA_WIDTH-1:0] line2_data0,
  output logic [DATA_WIDTH-1:0] line2_data1,
  output logic [DATA_WIDTH-1:0] line2_data2,
  output logic [3:0]            corner_type,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  state_t                state;
  logic                  active;
  logic                  last_loaded;
  logic [CW-1:0]         in_col, out_col;
  logic [RW-1:0]         in_row, out_row;
  logic [DATA_WIDTH-1:0] win  [3][3];
  logic [DATA_WIDTH-1:0] col1 [3];
  logic [DATA_WIDTH-1:0] col2 [3];
  logic [DATA_WIDTH-1:0] raw  [3][3];
  logic [DATA_WIDTH-1:0] nxt  [3][3];
  logic [3:0]            nxt_ct;
  logic [DATA_WIDTH-1:0] pix, tap1, tap2;
  logic slot_free, accept, fstep, shift, load;
  logic top, bot, left, right;

  assign slot_free = ~out_valid | out_ready;
  assign in_ready  = active & ((state == FILL) | ((state == STREAM) & slot_free));
  assign accept    = in_valid & in_ready;
  assign fstep     = (state == FLUSH) & ~last_loaded & slot_free;
  assign shift     = accept | fstep;
  assign load      = ((state == STREAM) & accept) | fstep;
  assign pix       = (state == FLUSH) ? '0 : in_data;

  assign top   = (out_row == '0);
  assign bot   = (out_row == RW'(IMG_HEIGHT - 1));
  assign left  = (out_col == '0);
  assign right = (out_col == CW'(IMG_WIDTH - 1));

  gauss_line_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_fifo_r (
    .clk(clk), .rst_n(rst_n), .shift_en(shift), .din(pix), .dout(tap1)
  );

  gauss_line_fifo #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH)) u_fifo_rm1 (
    .clk(clk), .rst_n(rst_n), .shift_en(shift), .din(tap1), .dout(tap2)
  );

`ifdef GAUSS_WIN_REPLICATE_EN
  logic [DATA_WIDTH-1:0] rowfix [3][3];
`endif

  // raw[line][0] is the incoming column (c+1); [1] and [2] are the two previous columns.
  always_comb begin
    raw[0][0] = pix;
    raw[1][0] = tap1;
    raw[2][0] = tap2;
    for (int k = 0; k < 3; k++) begin
      raw[k][1] = col1[k];
      raw[k][2] = col2[k];
    end
`ifdef GAUSS_WIN_REPLICATE_EN
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        rowfix[k][j] = ((k == 2 && top) || (k == 0 && bot)) ? raw[1][j] : raw[k][j];
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        nxt[k][j] = ((j == 2 && left) || (j == 0 && right)) ? rowfix[k][1] : rowfix[k][j];
    nxt_ct = CT_FULL;
`else
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 3; j++)
        nxt[k][j] = ((k == 2 && top) || (k == 0 && bot) || (j == 2 && left) || (j == 0 && right))
                    ? '0 : raw[k][j];
    nxt_ct = corner_code(top, bot, left, right);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      active      <= 1'b0;
      last_loaded <= 1'b0;
      in_col      <= '0;
      in_row      <= '0;
      out_col     <= '0;
      out_row     <= '0;
      out_valid   <= 1'b0;
      corner_type <= CT_IDLE;
      frame_done  <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        col1[k] <= '0;
        col2[k] <= '0;
        for (int j = 0; j < 3; j++) win[k][j] <= '0;
      end
    end else begin
      active     <= 1'b1;
      frame_done <= 1'b0;

      if (shift) begin
        for (int k = 0; k < 3; k++) begin
          col1[k] <= raw[k][0];
          col2[k] <= col1[k];
        end
      end

      if (accept) begin
        if (in_col == CW'(IMG_WIDTH - 1)) begin
          in_col <= '0;
          in_row <= (in_row == RW'(IMG_HEIGHT - 1)) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
      end

      if (load) begin
        win         <= nxt;
        corner_type <= nxt_ct;
        out_valid   <= 1'b1;
        if (right) begin
          out_col <= '0;
          out_row <= bot ? '0 : out_row + 1'b1;
        end else begin
          out_col <= out_col + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      case (state)
        FILL: begin
          if (accept && in_row == RW'(1) && in_col == '0) state <= STREAM;
        end
        STREAM: begin
          if (accept && in_row == RW'(IMG_HEIGHT - 1) && in_col == CW'(IMG_WIDTH - 1))
            state <= FLUSH;
        end
        FLUSH: begin
          if (fstep && bot && right) last_loaded <= 1'b1;
          if (last_loaded && out_valid && out_ready) begin
            last_loaded <= 1'b0;
            frame_done  <= 1'b1;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign line0_data0 = win[0][0];
  assign line0_data1 = win[0][1];
  assign line0_data2 = win[0][2];
  assign line1_data0 = win[1][0];
  assign line1_data1 = win[1][1];
  assign line1_data2 = win[1][2];
  assign line2_data0 = win[2][0];
  assign line2_data1 = win[2][1];
  assign line2_data2 = win[2][2];

endmodule

// File: tb/tb_gauss_window_gen.sv
// tb/tb_gauss_window_gen.sv - directed table-driven bench for gauss_window_gen on a 4x4 frame
module tb_gauss_window_gen;

  localparam int W = 4;
  localparam int H = 4;
  localparam int N = W * H;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] l0d0, l0d1, l0d2, l1d0, l1d1, l1d2, l2d0, l2d1, l2d2;
  logic [3:0] corner_type;
  logic       out_valid;
  logic       out_ready;
  logic       frame_done;

  gauss_window_gen #(.DATA_WIDTH(8), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .line0_data0(l0d0), .line0_data1(l0d1), .line0_data2(l0d2),
    .line1_data0(l1d0), .line1_data1(l1d1), .line1_data2(l1d2),
    .line2_data0(l2d0), .line2_data1(l2d1), .line2_data2(l2d2),
    .corner_type(corner_type), .out_valid(out_valid), .out_ready(out_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          k;
    logic [75:0] exp;
  } vec_t;

  vec_t        tbl [4];
  logic [75:0] q [$];
  logic [75:0] cur, prev_win;
  logic        prev_stall;
  int          n_vec = 0;
  int          n_bad = 0;
  int          done_cnt = 0;
  int          last_marks = 0;
  int          flush_cnt = 0;
  logic        toggle = 1'b0;

  assign cur = {corner_type, l0d0, l0d1, l0d2, l1d0, l1d1, l1d2, l2d0, l2d1, l2d2};

  function automatic logic [75:0] pk(int ct, int a, int b, int c, int d, int e, int f,
                                     int g, int h, int i);
    return {4'(ct), 8'(a), 8'(b), 8'(c), 8'(d), 8'(e), 8'(f), 8'(g), 8'(h), 8'(i)};
  endfunction

  function automatic logic [7:0] pixv(int r, int c);
`ifdef GAUSS_WIN_REPLICATE_EN
    if (r < 0) r = 0;
    if (r > H - 1) r = H - 1;
    if (c < 0) c = 0;
    if (c > W - 1) c = W - 1;
`else
    if (r < 0 || r > H - 1 || c < 0 || c > W - 1) return 8'd0;
`endif
    return 8'(r * W + c + 1);
  endfunction

  function automatic logic [75:0] exp_win(int k);
    int r, c, ct;
    logic [75:0] v;
    r = k / W;
    c = k % W;
`ifdef GAUSS_WIN_REPLICATE_EN
    ct = 8;
`else
    if      (r == 0 && c == 0)         ct = 1;
    else if (r == 0 && c == W - 1)     ct = 2;
    else if (r == H - 1 && c == 0)     ct = 5;
    else if (r == H - 1 && c == W - 1) ct = 6;
    else if (r == H - 1)               ct = 7;
    else if (c == 0)                   ct = 3;
    else if (c == W - 1)               ct = 4;
    else                               ct = 8;
`endif
    v = '0;
    v[75:72] = 4'(ct);
    for (int l = 0; l < 3; l++)
      for (int j = 0; j < 3; j++)
        v[71 - 8 * (3 * l + j) -: 8] = pixv(r + 1 - l, c + 1 - j);
    return v;
  endfunction

  task automatic check(input string name, input logic [75:0] got, input logic [75:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Output monitor: collects handshaken windows, checks stall stability and FLUSH behaviour.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
      flush_cnt  = 0;
    end else begin
      if (prev_stall) check("stall_hold", {out_valid, cur}, {1'b1, prev_win});
      prev_stall = out_valid && !out_ready;
      prev_win   = cur;
      if (out_valid && out_ready) begin
        q.push_back(cur);
        if (last_marks > done_cnt) begin
          flush_cnt++;
          check("flush_in_ready", {75'd0, in_ready}, 76'd0);
        end
      end
      if (frame_done) begin
        check("done_in_ready", {75'd0, in_ready}, 76'd1);
        if (!toggle) check("flush_windows", 76'(flush_cnt), 76'(W + 2));
        flush_cnt = 0;
        done_cnt++;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = toggle ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic feed(input int count);
    int budget;
    logic got;
    for (int i = 0; i < count; i++) begin
      in_data  = 8'((i % N) + 1);
      in_valid = 1'b1;
      got      = 1'b0;
      budget   = 0;
      while (!got && budget < 200) begin
        @(negedge clk);
        if (in_ready) got = 1'b1;
        @(posedge clk);
        #1;
        budget++;
      end
      if (!got) begin
        n_vec++;
        n_bad++;
        $display("FAIL input_accept: pixel %0d not accepted within %0d cycles", i, budget);
      end
      if ((i % N) == N - 1) last_marks++;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int b;
    b = 0;
    while (done_cnt < target && b < 2000) begin
      @(posedge clk);
      b++;
    end
    repeat (2) @(posedge clk);
    #1;
    check("frame_done_count", 76'(done_cnt), 76'(target));
  endtask

  task automatic check_frames(input string name, input int nwin);
    check({name, "_count"}, 76'(q.size()), 76'(nwin));
    for (int i = 0; i < nwin && i < q.size(); i++)
      check(name, q[i], exp_win(i % N));
  endtask

  initial begin
`ifdef GAUSS_WIN_REPLICATE_EN
    tbl[0] = '{0,  pk(8, 6, 5, 5,   2, 1, 1,   2, 1, 1)};
    tbl[1] = '{5,  pk(8, 11, 10, 9, 7, 6, 5,   3, 2, 1)};
    tbl[2] = '{15, pk(8, 16, 16, 15, 16, 16, 15, 12, 12, 11)};
    tbl[3] = '{3,  pk(8, 8, 8, 7,   4, 4, 3,   4, 4, 3)};
`else
    tbl[0] = '{0,  pk(1, 6, 5, 0,   2, 1, 0,   0, 0, 0)};
    tbl[1] = '{5,  pk(8, 11, 10, 9, 7, 6, 5,   3, 2, 1)};
    tbl[2] = '{15, pk(6, 0, 0, 0,   0, 16, 15, 0, 12, 11)};
    tbl[3] = '{3,  pk(2, 0, 8, 7,   0, 4, 3,   0, 0, 0)};
`endif

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {cur[71:0], 4'(0)}, 76'd0);
    check("reset_flags", {72'd0, corner_type}, {in_ready, out_valid, frame_done, 73'd0} >> 73);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("fill_in_ready", {75'd0, in_ready}, 76'd1);
    @(posedge clk);
    #1;

    // Unstalled frame: full model comparison plus hand-computed spot vectors.
    q.delete();
    feed(N);
    wait_done(1);
    check_frames("frame_plain", N);
    for (int v = 0; v < 4; v++)
      if (tbl[v].k < q.size()) check("hand_vector", q[tbl[v].k], tbl[v].exp);

    // out_ready toggling every cycle.
    q.delete();
    toggle = 1'b1;
    feed(N);
    wait_done(2);
    toggle = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_frames("frame_toggle", N);

    // Reset after 7 inputs, then a clean frame.
    feed(7);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midreset_valid", {74'd0, out_valid, in_ready}, 76'd0);
    q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    feed(N);
    wait_done(3);
    check_frames("frame_after_reset", N);

    // Back-to-back frames.
    q.delete();
    feed(2 * N);
    wait_done(5);
    check_frames("frame_b2b", 2 * N);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
